// File: rtl/latch_array_fifo_pkg.sv
// Shared constants and elaboration helpers for the latch-array FIFO.
package latch_array_fifo_pkg;

  // Value each rd_data bit takes while the FIFO is empty or in reset.
  localparam logic RD_RESET_BIT = 1'b0;

  // Ceiling log2, used to derive the pointer index width from DEPTH.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/latch_array_fifo_latch_word.sv
// One FIFO storage word: a WIDTH-bit level-sensitive latch, open while clk is low.
module latch_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: always_latch marks the latch as intentional; the storage is not
  // reset because reset closes the enable and the read mux masks stale words.
  always_latch begin
    if (en && !clk && rst_n) q <= d;
  end

endmodule

// File: rtl/latch_array_fifo.sv
// Same-clock FIFO: flop pointers/flags/staging around a DEPTH x WIDTH latch array, FWFT read.
module latch_array_fifo
  import latch_array_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]      PTR_DEPTH = (AW+1)'(DEPTH);
  localparam logic [DEPTH-1:0] SEL_ONE   = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr, rd_ptr, cm_ptr;
  logic [AW:0]      used;
  logic [WIDTH-1:0] wdat_q;
  logic [DEPTH-1:0] sel_q;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic             wr_go, rd_go;

  // Flags depend only on registered pointers, so wr_en/rd_en never reach them.
  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == PTR_DEPTH);
  assign empty = (rd_ptr == cm_ptr);
  assign count = used;
  assign wr_go = wr_en && !full;
  assign rd_go = rd_en && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cm_ptr <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      // A word becomes readable one cycle after acceptance, once its latch has closed.
      cm_ptr <= wr_ptr;
      sel_q  <= '0;
      if (wr_go) begin
        wdat_q <= wr_data;
        sel_q  <= SEL_ONE << wr_ptr[AW-1:0];
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_go) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full)  ovf <= 1'b1;
      if (rd_en && empty) udf <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    latch_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sel_q[i]),
      .d     (wdat_q),
      .q     (word_q[i])
    );
  end

  assign rd_data   = empty ? {WIDTH{RD_RESET_BIT}} : word_q[rd_ptr[AW-1:0]];
  assign rd_data_b = ~rd_data;

endmodule

// File: tb/tb_latch_array_fifo.sv
// Directed bench for latch_array_fifo: scoreboard queue of expected pops plus flag checks.
module tb_latch_array_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] rd_data_b;
  logic       empty;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int vectors;
  int miscompares;
  logic [7:0] sb [$];

  latch_array_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_data_b (rd_data_b),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    sb.push_back(d);
    step();
  endtask

  // Monitor: a pop happens at the next rising edge whenever rd_en=1 and empty=0.
  always @(negedge clk) begin
    logic [7:0] e, eb;
    if (rst_n && rd_en && !empty) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", rd_data, $time);
      end else begin
        e  = sb.pop_front();
        eb = ~e;
        check("pop_data", 32'(rd_data), 32'(e));
        check("pop_data_b", 32'(rd_data_b), 32'(eb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset / idle state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_rd_data_b", 32'(rd_data_b), 32'hFF);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_udf", 32'(udf), 32'd0);

    // Single write: readable only after the second edge
    write_push(8'hA5);
    wr_en = 1'b0;
    check("w1_count", 32'(count), 32'd1);
    check("w1_empty_still", 32'(empty), 32'd1);
    step();
    check("w1_empty_clear", 32'(empty), 32'd0);
    check("w1_rd_data", 32'(rd_data), 32'hA5);
    check("w1_rd_data_b", 32'(rd_data_b), 32'h5A);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("w1_drained", 32'(empty), 32'd1);

    // Fill to full, refused fifth write sets ovf, then drain in order
    for (int i = 1; i <= 4; i++) write_push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    wr_data = 8'h05;
    step();
    wr_en = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count_kept", 32'(count), 32'd4);
    rd_en = 1'b1;
    repeat (4) step();
    rd_en = 1'b0;
    check("fill_drained_empty", 32'(empty), 32'd1);
    check("fill_drained_count", 32'(count), 32'd0);

    // Fill to 3, then six concurrent write+pop cycles with wrapping pointers
    for (int i = 1; i <= 3; i++) write_push(8'(8'h20 + i));
    check("stream_pre_count", 32'(count), 32'd3);
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_push(8'(8'h10 + i));
      check("stream_count", 32'(count), 32'd3);
    end
    wr_en = 1'b0;
    repeat (3) step();
    rd_en = 1'b0;
    check("stream_drained", 32'(empty), 32'd1);

    // Pop on empty sets udf; pop alongside first write is ignored
    rd_en = 1'b1;
    step();
    check("udf_set", 32'(udf), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    write_push(8'h77);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("udf_wr_count", 32'(count), 32'd1);
    step();
    check("udf_wr_data", 32'(rd_data), 32'h77);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;

    // Reset dropped during the low phase of a write with two entries held
    write_push(8'h41);
    write_push(8'h42);
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'h00);
    check("mid_rst_rd_data_b", 32'(rd_data_b), 32'hFF);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_udf", 32'(udf), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    write_push(8'h3C);
    wr_en = 1'b0;
    step();
    check("post_rst_rd_data", 32'(rd_data), 32'h3C);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_empty", 32'(empty), 32'd1);
    check("sb_all_popped", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/latch_array_fifo.md
Name: latch_array_fifo

Overview:
- Synchronous FIFO with level-sensitive latch storage, the parametrised successor to the single-bit cross-coupled latch.
- Storage is a DEPTH x WIDTH array of latches. Pointers, flags and staging are edge-triggered flops.
- Read side is first-word-fall-through, with a true output and a complement output (q/qb style).
- Used as a low-area buffer between clocked stages in the same clock domain.

Parameters:
- WIDTH, 8: data bits per entry; legal range 1 or more.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH): derived pointer index width; not to be overridden.

Ports:
- clk  input  1  single clock; all flops rise-edge; latches transparent while clk low.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request, sampled at rising edge.
- wr_data  input  WIDTH  write data, sampled at rising edge with wr_en.
- full  output  1  no free entry; write refused.
- rd_en  input  1  pop request, sampled at rising edge.
- rd_data  output  WIDTH  head entry, valid whenever empty=0.
- rd_data_b  output  WIDTH  bitwise complement of rd_data.
- empty  output  1  no committed entry readable.
- count  output  AW+1  accepted-but-not-popped entries, including the pending write.
- ovf  output  1  sticky: wr_en seen while full.
- udf  output  1  sticky: rd_en seen while empty.

Behaviour:
- Reset is asynchronous on rst_n low and deasserts synchronously to clk. While asserted and after it:
  - wr_ptr = rd_ptr = cm_ptr = 0; all latch write-selects = 0 (forced immediately, closing every latch).
  - empty=1, full=0, count=0, ovf=udf=0, rd_data=0, rd_data_b=all ones.
  - Latch contents are don't-care after reset.
- Pointers are AW+1 bits (wrap bit plus index) and wrap modulo 2*DEPTH.
- Write is accepted at rising edge E when wr_en=1 and full=0. At E:
  - wr_data is captured into the staging flop wdat_q.
  - sel_q is set to the one-hot decode of wr_ptr[AW-1:0].
  - wr_ptr increments.
- Latch fill: entry sel_q is transparent to wdat_q while clk is low after E, and closes at E+1. sel_q clears at E+1 unless another write is accepted.
- Commit: cm_ptr <= wr_ptr on every edge, a one-cycle delay. An entry becomes readable one full cycle after acceptance, so empty falls after E+1, never at E.
- Flag and count equations:
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - empty = (rd_ptr == cm_ptr).
  - count = wr_ptr - rd_ptr.
- Pop is accepted at a rising edge when rd_en=1 and empty=0; rd_ptr increments.
- Read path:
  - rd_data = latch[rd_ptr[AW-1:0]] when empty=0, else 0. This is combinational from the latches and rd_ptr.
  - rd_data_b = ~rd_data exactly, with no extra latency.
- Simultaneous write and pop:
  - Both proceed when their own condition holds; count is unchanged.
  - If full, only the pop proceeds; the write is refused and ovf is set.
  - If empty (including the case where only an uncommitted entry exists), only the write proceeds and udf is set.
- Write/read slot hazards:
  - The entry being written never equals the head entry of a non-empty queue.
  - A slot freed by a pop at edge E can be rewritten no earlier than E, with its latch open in the following low phase.
- Sticky flags: ovf and udf set on the first violating edge, hold until reset, and do not alter pointers.
- Reset mid-write (rst_n falls during the clk-low phase): sel_q clears asynchronously, the latch closes, and the partial write is discarded.
- No combinational path from wr_en or rd_en to full, empty or count.
- Latch inference: permitted only in the storage sub-module. The staging flop guarantees latch data is stable for the whole transparent phase.

Decomposition:
- Shared include latch_fifo_defs.vh holds:
  - the log2 helper;
  - pointer increment/compare macros;
  - the rd_data reset value constant (0).
- One sub-module, latch_word:
  - ports: clk, rst_n, en, d[WIDTH], q[WIDTH];
  - transparent when en & ~clk & rst_n, otherwise holds;
  - instantiated DEPTH times via generate.
- Everything else (pointers, decode, flags, read mux, complement) lives in the top module.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, rd_data=0x00, rd_data_b=0xFF, ovf=udf=0.
- Write 0xA5 at edge 1 with no rd_en:
  - count=1 after edge 1, empty still 1;
  - after edge 2: empty=0, rd_data=0xA5, rd_data_b=0x5A.
- Write 0x01..0x04 on consecutive edges (DEPTH=4) → full=1 after the 4th edge. A 5th write of 0x05 is refused and sets ovf=1. Pops then return 0x01,0x02,0x03,0x04 in order.
- Fill to 3, then assert wr_en and rd_en together for 6 cycles with data 0x10..0x15:
  - count stays 3, pointers wrap;
  - outputs continue the sequence in order.
- rd_en on an empty FIFO, and at the same edge as the first write → udf=1, that read is ignored, and the written word is still returned later.
- Drop rst_n during the clk-low phase of a write with 2 entries held → immediately empty=1, count=0, rd_data=0. After release, write 0x3C → read back 0x3C.
